line_scaler_ring: RTL

- Parametrised multi-line ring buffer and scaler between the legacy (PAL-rate) pixel stream and the HD output timing.
- Both sides run on a single system clock. Each side is paced by pixel strobes.
- Horizontal scaling uses a fractional DDA step. 4:3 pillarbox is a runtime mode.
- Vertical rate mismatch is absorbed by repeating lines (underflow) or dropping lines (overflow), with sticky status flags.
- Feeds the ADV7511 output path in place of the fixed 4-line upsampler.

---
 rtl/line_scaler_ring.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/line_scaler_ring.sv
// Multi-line ring buffer with a fractional horizontal scaler between the legacy
// pixel stream and HD output timing; line repeat/drop absorbs vertical rate mismatch.
module line_scaler_ring #(
    parameter int PIX_W     = 24,
    parameter int LINES     = 4,
    parameter int ADDR_W    = 11,
    parameter int OUT_H_RES = 1280,
    parameter int BAR_W     = 160,
    parameter int FRAC_W    = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_pix_en,
    input  logic [PIX_W-1:0]           in_pix,
    input  logic                       in_line_start,
    input  logic                       in_frame_start,
    input  logic                       out_pix_en,
    input  logic                       out_line_start,
    input  logic                       four_three,
    input  logic [ADDR_W+FRAC_W-1:0]   h_step,
    input  logic [ADDR_W-1:0]          h_offset,
    input  logic                       sts_clr,
    output logic [PIX_W-1:0]           out_pix,
    output logic                       out_valid,
    output logic                       o_frame_end,
    output logic                       sts_overflow,
    output logic                       sts_underflow,
    output logic [$clog2(LINES):0]     fill
);
    localparam int LW     = $clog2(LINES);
    localparam int FW     = LW + 1;
    localparam int AW     = ADDR_W + FRAC_W;
    localparam int HW     = $clog2(OUT_H_RES + 1);
    localparam int RAM_AW = LW + ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic [PIX_W-1:0]  mem [1<<RAM_AW];
    logic [PIX_W-1:0]  rd_data;
    logic [ADDR_W-1:0] len [LINES];
    logic [LW-1:0]     wr_slot, rd_slot, cur_slot;
    logic [ADDR_W-1:0] wr_addr, wr_addr_nxt, cur_len, idx;
    logic [AW-1:0]     acc, step;
    logic [HW-1:0]     h_pos;
    logic              mode_ft, in_win, blank, blank_q;
    logic              wr_en, commit, consume, starve, drop;
    logic [1:0]        vld_pipe;

    always_comb begin
        wr_en       = in_pix_en && (wr_addr != ADDR_MAX);
        wr_addr_nxt = wr_en ? wr_addr + 1'b1 : wr_addr;
        // a pixel coinciding with the line pulse counts toward the ending line
        commit  = in_line_start && (wr_addr_nxt != '0);
        consume = out_line_start && (fill != '0);
        starve  = out_line_start && (fill == '0);
        drop    = commit && !consume && (fill == FW'(LINES-1));
    end

    always_comb begin
        in_win = (h_pos < HW'(OUT_H_RES));
        if (mode_ft)
            in_win = in_win && (h_pos >= HW'(BAR_W)) && (h_pos < HW'(OUT_H_RES-BAR_W));
        idx   = acc[AW-1:FRAC_W];
        blank = !in_win || (idx >= cur_len);
    end

    // RAM: sync read, read-before-write on the same slot
    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_slot, wr_addr}] <= in_pix;
        if (out_pix_en) rd_data <= mem[{cur_slot, idx}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            wr_slot <= '0;
            for (int i = 0; i < LINES; i++) len[i] <= '0;
        end else if (commit) begin
            len[wr_slot] <= wr_addr_nxt;
            wr_slot      <= wr_slot + 1'b1;
            wr_addr      <= '0;
        end else begin
            wr_addr <= wr_addr_nxt;
        end
    end

    // cur_slot is the line on screen; rd_slot is the oldest committed unread line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_slot  <= '0;
            cur_slot <= '0;
            cur_len  <= '0;
            fill     <= '0;
        end else begin
            if (consume) begin
                cur_slot <= rd_slot;
                cur_len  <= len[rd_slot];
            end
            if (consume || drop) rd_slot <= rd_slot + 1'b1;
            if (!drop) fill <= fill + FW'(commit) - FW'(consume);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sts_overflow  <= 1'b0;
            sts_underflow <= 1'b0;
            o_frame_end   <= 1'b0;
        end else begin
            sts_overflow  <= drop   || (sts_overflow  && !sts_clr);
            sts_underflow <= starve || (sts_underflow && !sts_clr);
            o_frame_end   <= in_frame_start;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_pos   <= '0;
            acc     <= '0;
            step    <= '0;
            mode_ft <= 1'b0;
        end else if (out_line_start) begin
            h_pos   <= '0;
            acc     <= {h_offset, {FRAC_W{1'b0}}};
            step    <= h_step;
            mode_ft <= four_three;
        end else if (out_pix_en) begin
            if (in_win) acc <= acc + step;
            if (h_pos != HW'(OUT_H_RES)) h_pos <= h_pos + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            blank_q  <= 1'b1;
            out_pix  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], out_pix_en};
            if (out_pix_en) blank_q <= blank;
            if (vld_pipe[0]) out_pix <= blank_q ? '0 : rd_data;
        end
    end

    assign out_valid = vld_pipe[1];
endmodule
